instruction_fetch_unit: RTL and testbench

Fetch stage that feeds the program memory ROM and registers its output. It owns the program counter and drives the ROM word address. It captures the returned instruction into the IF/ID pipeline register. It handles stall, branch/jump redirect with wrong-path flush, and detection of misaligned or out-of-range fetches. It sits between the ROM and the decode stage.

---
 rtl/fetch_defs_pkg.sv | 12 +
 rtl/if_id_register.sv | 49 ++++
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_defs_pkg.sv
// rtl/fetch_defs_pkg.sv - shared fetch constants and FSM state encoding
package fetch_defs;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with flush-over-enable priority
module if_id_register #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP        = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  input  logic [31:0]           i_pc,
  input  logic [31:0]           i_pc_plus4,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic [31:0]           o_pc,
  output logic [31:0]           o_pc_plus4,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_instruction;
  logic [31:0]           r_pc;
  logic [31:0]           r_pc_plus4;
  logic                  r_valid;

  // A flush inserts a full bubble: NOP with cleared PC fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instruction <= NOP;
      r_pc          <= 32'd0;
      r_pc_plus4    <= 32'd0;
      r_valid       <= 1'b0;
    end else if (i_flush) begin
      r_instruction <= NOP;
      r_pc          <= 32'd0;
      r_pc_plus4    <= 32'd0;
      r_valid       <= 1'b0;
    end else if (i_enable) begin
      r_instruction <= i_instruction;
      r_pc          <= i_pc;
      r_pc_plus4    <= i_pc_plus4;
      r_valid       <= 1'b1;
    end
  end

  assign o_instruction = r_instruction;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = r_pc_plus4;
  assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, ROM addressing, fault FSM and IF/ID capture
module instruction_fetch_unit #(
  parameter logic [31:0]           TEXT_BASE    = fetch_defs::TEXT_BASE,
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] NOP          = fetch_defs::NOP
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            Stall_i,
  input  logic                            Redirect_i,
  input  logic [31:0]                     Redirect_Target_i,
  output logic [$clog2(MEMORY_DEPTH)-1:0] Rom_Address_o,
  input  logic [DATA_WIDTH-1:0]           Rom_Instruction_i,
  output logic [31:0]                     PC_o,
  output logic [DATA_WIDTH-1:0]           IF_ID_Instruction_o,
  output logic [31:0]                     IF_ID_PC_o,
  output logic [31:0]                     IF_ID_PC_Plus4_o,
  output logic                            IF_ID_Valid_o,
  output logic                            Fetch_Fault_o
);

  import fetch_defs::*;

  localparam int          AW        = $clog2(MEMORY_DEPTH);
  localparam logic [31:0] ROM_BYTES = 32'(4 * MEMORY_DEPTH);

  fetch_state_t r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  w_offset;
  logic [31:0]  w_pc_plus4;
  logic         w_pc_bad;
  logic         w_flush;
  logic         w_enable;

  assign w_offset   = r_pc - TEXT_BASE;
  assign w_pc_plus4 = r_pc + 32'd4;
  // Wrap past 0xFFFFFFFC lands below TEXT_BASE and is caught here too.
  assign w_pc_bad   = (r_pc < TEXT_BASE) || (w_offset >= ROM_BYTES) || (r_pc[1:0] != 2'b00);

  assign Rom_Address_o = w_pc_bad ? '0 : w_offset[AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_pc    <= TEXT_BASE;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_flush      = 1'b0;
    w_enable     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_pc_bad) begin
          w_state_next = HALT;
          w_flush      = 1'b1;
        end else if (Redirect_i) begin
          w_pc_next = Redirect_Target_i;
          w_flush   = 1'b1;
        end else if (!Stall_i) begin
          w_pc_next = w_pc_plus4;
          w_enable  = 1'b1;
        end
      end
      HALT: begin
        w_state_next = HALT;
      end
      default: begin
        w_state_next = HALT;
      end
    endcase
  end

  if_id_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP        (NOP)
  ) u_if_id (
    .clk           (clk),
    .rst_n         (reset),
    .i_flush       (w_flush),
    .i_enable      (w_enable),
    .i_instruction (Rom_Instruction_i),
    .i_pc          (r_pc),
    .i_pc_plus4    (w_pc_plus4),
    .o_instruction (IF_ID_Instruction_o),
    .o_pc          (IF_ID_PC_o),
    .o_pc_plus4    (IF_ID_PC_Plus4_o),
    .o_valid       (IF_ID_Valid_o)
  );

  assign PC_o          = r_pc;
  assign Fetch_Fault_o = (r_state == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for the fetch unit
module tb_instruction_fetch_unit;

  localparam logic [31:0] TB_BASE = 32'h0040_0000;
  localparam logic [31:0] TB_NOP  = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        Stall_i;
  logic        Redirect_i;
  logic [31:0] Redirect_Target_i;
  logic [5:0]  Rom_Address_o;
  logic [31:0] Rom_Instruction_i;
  logic [31:0] PC_o;
  logic [31:0] IF_ID_Instruction_o;
  logic [31:0] IF_ID_PC_o;
  logic [31:0] IF_ID_PC_Plus4_o;
  logic        IF_ID_Valid_o;
  logic        Fetch_Fault_o;

  logic [31:0] rom [64];

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  addr;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic [31:0] ifpc4;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
  logic        m_valid, m_halt;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .Stall_i             (Stall_i),
    .Redirect_i          (Redirect_i),
    .Redirect_Target_i   (Redirect_Target_i),
    .Rom_Address_o       (Rom_Address_o),
    .Rom_Instruction_i   (Rom_Instruction_i),
    .PC_o                (PC_o),
    .IF_ID_Instruction_o (IF_ID_Instruction_o),
    .IF_ID_PC_o          (IF_ID_PC_o),
    .IF_ID_PC_Plus4_o    (IF_ID_PC_Plus4_o),
    .IF_ID_Valid_o       (IF_ID_Valid_o),
    .Fetch_Fault_o       (Fetch_Fault_o)
  );

  assign Rom_Instruction_i = rom[Rom_Address_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic model_bad(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - TB_BASE;
    return (pc < TB_BASE) || (off >= 32'd256) || (pc[1:0] != 2'b00);
  endfunction

  function automatic logic [5:0] model_addr(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - TB_BASE;
    return model_bad(pc) ? 6'd0 : off[7:2];
  endfunction

  task automatic model_reset();
    m_pc = TB_BASE; m_instr = TB_NOP; m_ifpc = 0; m_ifpc4 = 0;
    m_valid = 1'b0; m_halt = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] tgt);
    if (m_halt) return;
    if (model_bad(m_pc)) begin
      m_halt = 1'b1; m_instr = TB_NOP; m_ifpc = 0; m_ifpc4 = 0; m_valid = 1'b0;
    end else if (rd) begin
      m_pc = tgt; m_instr = TB_NOP; m_ifpc = 0; m_ifpc4 = 0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = rom[model_addr(m_pc)]; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
      m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("pc",      PC_o,                 e.pc);
    check("addr",    32'(Rom_Address_o),   32'(e.addr));
    check("instr",   IF_ID_Instruction_o,  e.instr);
    check("ifpc",    IF_ID_PC_o,           e.ifpc);
    check("ifpc4",   IF_ID_PC_Plus4_o,     e.ifpc4);
    check("valid",   32'(IF_ID_Valid_o),   32'(e.valid));
    check("fault",   32'(Fetch_Fault_o),   32'(e.fault));
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    exp_t e;
    Stall_i = st; Redirect_i = rd; Redirect_Target_i = tgt;
    model_edge(st, rd, tgt);
    e.pc = m_pc; e.addr = model_addr(m_pc); e.instr = m_instr; e.ifpc = m_ifpc;
    e.ifpc4 = m_ifpc4; e.valid = m_valid; e.fault = m_halt;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compare_front();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},    PC_o,                TB_BASE);
    check({tag, "_instr"}, IF_ID_Instruction_o, TB_NOP);
    check({tag, "_ifpc"},  IF_ID_PC_o,          32'd0);
    check({tag, "_ifpc4"}, IF_ID_PC_Plus4_o,    32'd0);
    check({tag, "_valid"}, 32'(IF_ID_Valid_o),  32'd0);
    check({tag, "_fault"}, 32'(Fetch_Fault_o),  32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + (i * 32'h0001_0101);
    rom[0] = 32'h0050_0293;
    rom[1] = 32'h00A0_0313;
    rom[2] = 32'h0062_83B3;

    reset = 1'b0; Stall_i = 1'b0; Redirect_i = 1'b0; Redirect_Target_i = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    check("rst_addr", 32'(Rom_Address_o), 32'd0);
    reset = 1'b1;

    step(1'b0, 1'b0, 0);
    check("plan_w0", IF_ID_Instruction_o, 32'h0050_0293);
    check("plan_pc0", IF_ID_PC_o, 32'h0040_0000);
    step(1'b0, 1'b0, 0);
    check("plan_w1", IF_ID_Instruction_o, 32'h00A0_0313);
    check("plan_pc1", IF_ID_PC_o, 32'h0040_0004);

    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    check("stall_pc", PC_o, 32'h0040_0008);
    check("stall_addr", 32'(Rom_Address_o), 32'd2);
    check("stall_ifpc", IF_ID_PC_o, 32'h0040_0004);
    step(1'b0, 1'b0, 0);
    check("plan_w2", IF_ID_Instruction_o, 32'h0062_83B3);
    check("plan_pc2", IF_ID_PC_o, 32'h0040_0008);

    step(1'b1, 1'b1, 32'h0040_0020);
    check("redir_pc", PC_o, 32'h0040_0020);
    check("redir_bubble", 32'(IF_ID_Valid_o), 32'd0);
    step(1'b0, 1'b0, 0);
    check("redir_ifpc", IF_ID_PC_o, 32'h0040_0020);
    check("redir_instr", IF_ID_Instruction_o, rom[8]);

    for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 2) == 0), 1'b0, 0);

    step(1'b0, 1'b1, 32'h0040_00F0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
    check("end_instr", IF_ID_Instruction_o, rom[63]);
    check("end_ifpc", IF_ID_PC_o, 32'h0040_00FC);
    check("oob_addr", 32'(Rom_Address_o), 32'd0);
    step(1'b0, 1'b0, 0);
    check("oob_fault", 32'(Fetch_Fault_o), 32'd1);
    step(1'b0, 1'b1, 32'h0040_0000);

    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 0);
    check("restart_pc", IF_ID_PC_o, 32'h0040_0000);
    step(1'b0, 1'b0, 0);

    step(1'b0, 1'b1, 32'h0040_0022);
    check("mis_pc", PC_o, 32'h0040_0022);
    check("mis_nofault", 32'(Fetch_Fault_o), 32'd0);
    step(1'b0, 1'b0, 0);
    check("mis_fault", 32'(Fetch_Fault_o), 32'd1);
    step(1'b0, 1'b1, 32'h0040_0010);
    step(1'b1, 1'b1, 32'h0040_0000);
    check("halt_pc", PC_o, 32'h0040_0022);

    reset = 1'b0;
    #1 model_reset();
    check_reset_values("rst2");
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 32'h0030_0000);
    step(1'b0, 1'b0, 0);
    check("low_fault", 32'(Fetch_Fault_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
